// File: rtl/iso7816_char_tx.sv
// ISO7816-3 T=0 character transmitter: start bit, 8 data bits, parity, guard time.
// Define ISO7816_TX_ERROR_CHECK_EN to enable error-signal sampling and retransmission.
module iso7816_char_tx #(
  parameter int unsigned ETU_WIDTH   = 16,
  parameter int unsigned GUARD_WIDTH = 8,
  parameter int unsigned MAX_RETRY   = 4
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic [ETU_WIDTH-1:0]   clocksPerEtu,
  input  logic [GUARD_WIDTH-1:0] extraGuard,
  input  logic                   inverseConv,
  input  logic [7:0]             dataIn,
  input  logic                   startTx,
  output logic                   txReady,
  output logic                   serialOut,
  input  logic                   serialIn,
  output logic                   txDone,
  output logic                   txError,
  output logic [2:0]             retryCount
);

  // Wide enough to count up to ETU 11 + the largest extraGuard.
  localparam int unsigned IdxWidth = ((GUARD_WIDTH > 4) ? GUARD_WIDTH : 4) + 1;

  typedef enum logic [2:0] {StIdle, StSend, StCheck, StRecover, StGuard} stateT;

  stateT                  stateQ, stateD;
  logic [ETU_WIDTH-1:0]   etuCntQ, etuCntD;
  logic [IdxWidth-1:0]    bitIdxQ, bitIdxD;
  logic [ETU_WIDTH-1:0]   cpeQ, cpeD;
  logic [GUARD_WIDTH-1:0] guardQ, guardD;
  logic                   invQ, invD;
  logic [7:0]             dataQ, dataD;
  logic                   doneQ, doneD;
  logic                   errorQ, errorD;
  logic                   etuLast;
  logic [IdxWidth-1:0]    guardEnd;
  logic [9:0]             frame;

`ifdef ISO7816_TX_ERROR_CHECK_EN
  logic [2:0] retryQ, retryD;
  logic       lineUpQ, lineUpD;
`else
  logic unusedSerialIn;
  assign unusedSerialIn = serialIn;
`endif

  assign etuLast  = (etuCntQ == (cpeQ - ETU_WIDTH'(1)));
  assign guardEnd = IdxWidth'(11) + IdxWidth'(guardQ);

  always_comb begin
    stateD  = stateQ;
    cpeD    = cpeQ;
    guardD  = guardQ;
    invD    = invQ;
    dataD   = dataQ;
    doneD   = 1'b0;
    errorD  = 1'b0;
`ifdef ISO7816_TX_ERROR_CHECK_EN
    retryD  = retryQ;
    lineUpD = lineUpQ;
`endif
    // Free-running ETU tick shared by every non-idle state.
    if (etuLast) begin
      etuCntD = '0;
      bitIdxD = bitIdxQ + IdxWidth'(1);
    end else begin
      etuCntD = etuCntQ + ETU_WIDTH'(1);
      bitIdxD = bitIdxQ;
    end

    unique case (stateQ)
      StIdle: begin
        etuCntD = '0;
        bitIdxD = '0;
        if (startTx) begin
          stateD = StSend;
          cpeD   = clocksPerEtu;
          guardD = extraGuard;
          invD   = inverseConv;
          dataD  = dataIn;
`ifdef ISO7816_TX_ERROR_CHECK_EN
          retryD = '0;
`endif
        end
      end
      StSend: begin
        if (etuLast && (bitIdxQ == IdxWidth'(9))) begin
`ifdef ISO7816_TX_ERROR_CHECK_EN
          stateD = StCheck;
`else
          stateD = StGuard;
`endif
        end
      end
`ifdef ISO7816_TX_ERROR_CHECK_EN
      StCheck: begin
        if ((bitIdxQ == IdxWidth'(11)) && (etuCntQ == '0)) begin
          if (serialIn) begin
            stateD = StGuard;
          end else if (int unsigned'(retryQ) < MAX_RETRY) begin
            stateD  = StRecover;
            lineUpD = 1'b0;
          end else begin
            stateD  = StIdle;
            errorD  = 1'b1;
            etuCntD = '0;
            bitIdxD = '0;
          end
        end
      end
      StRecover: begin
        if (!lineUpQ) begin
          // The cycle the line is seen high counts as the first of the two ETUs.
          bitIdxD = '0;
          etuCntD = serialIn ? ETU_WIDTH'(1) : '0;
          lineUpD = serialIn;
        end else if (etuLast && (bitIdxQ == IdxWidth'(1))) begin
          stateD  = StSend;
          etuCntD = '0;
          bitIdxD = '0;
          retryD  = retryQ + 3'd1;
        end
      end
`endif
      StGuard: begin
        if (etuLast && (bitIdxQ == guardEnd)) begin
          stateD  = StIdle;
          doneD   = 1'b1;
          etuCntD = '0;
          bitIdxD = '0;
        end
      end
      default: begin
        stateD  = StIdle;
        etuCntD = '0;
        bitIdxD = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      stateQ  <= StIdle;
      etuCntQ <= '0;
      bitIdxQ <= '0;
      cpeQ    <= '0;
      guardQ  <= '0;
      invQ    <= 1'b0;
      dataQ   <= '0;
      doneQ   <= 1'b0;
      errorQ  <= 1'b0;
`ifdef ISO7816_TX_ERROR_CHECK_EN
      retryQ  <= '0;
      lineUpQ <= 1'b0;
`endif
    end else begin
      stateQ  <= stateD;
      etuCntQ <= etuCntD;
      bitIdxQ <= bitIdxD;
      cpeQ    <= cpeD;
      guardQ  <= guardD;
      invQ    <= invD;
      dataQ   <= dataD;
      doneQ   <= doneD;
      errorQ  <= errorD;
`ifdef ISO7816_TX_ERROR_CHECK_EN
      retryQ  <= retryD;
      lineUpQ <= lineUpD;
`endif
    end
  end

  // Line levels per bit index; inverse convention sends complemented data MSB first.
  always_comb begin
    frame = '0;
    for (int i = 0; i < 8; i++) begin
      frame[i+1] = invQ ? ~dataQ[7-i] : dataQ[i];
    end
    frame[9] = invQ ? ~(^dataQ) : ^dataQ;
  end

  assign serialOut = (stateQ == StSend) ? frame[bitIdxQ[3:0]] : 1'b1;
  assign txReady   = (stateQ == StIdle);
  assign txDone    = doneQ;

`ifdef ISO7816_TX_ERROR_CHECK_EN
  assign txError    = errorQ;
  assign retryCount = retryQ;
`else
  assign txError    = 1'b0;
  assign retryCount = 3'd0;
  logic unusedError;
  assign unusedError = errorQ;
`endif

endmodule

// File: tb/tb_iso7816_char_tx.sv
// Self-checking bench for iso7816_char_tx: vector table of characters plus
// hand-written guard, back-to-back, error/retry and reset sequences.
module tb_iso7816_char_tx;

  logic        clk;
  logic        nReset;
  logic [15:0] clocksPerEtu;
  logic [7:0]  extraGuard;
  logic        inverseConv;
  logic [7:0]  dataIn;
  logic        startTx;
  logic        txReady;
  logic        serialOut;
  logic        serialIn;
  logic        txDone;
  logic        txError;
  logic [2:0]  retryCount;
  logic        errPull;

  // Open-drain line: card pulls low through errPull.
  assign serialIn = serialOut & ~errPull;

  iso7816_char_tx dut (
    .clk          (clk),
    .nReset       (nReset),
    .clocksPerEtu (clocksPerEtu),
    .extraGuard   (extraGuard),
    .inverseConv  (inverseConv),
    .dataIn       (dataIn),
    .startTx      (startTx),
    .txReady      (txReady),
    .serialOut    (serialOut),
    .serialIn     (serialIn),
    .txDone       (txDone),
    .txError      (txError),
    .retryCount   (retryCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int doneSeen = 0;
  int errSeen = 0;
  int bothSeen = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (txDone) doneSeen <= doneSeen + 1;
    if (txError) errSeen <= errSeen + 1;
    if (txDone && txError) bothSeen <= bothSeen + 1;
  end

  int nChecks = 0;
  int nFail = 0;
  int acceptCyc = 0;

  typedef struct {
    logic [7:0] data;
    logic       inv;
    logic [7:0] guard;
    int         cpe;
    logic [9:0] levels;  // levels[k] = expected line level during ETU k
    int         len;     // cycles from accept edge to txDone
  } vecT;

  vecT vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic accept();
    startTx = 1'b1;
    @(posedge clk);
    #1;
    acceptCyc = cyc;
    startTx = 1'b0;
  endtask

  task automatic waitTo(input int j);
    while (cyc - acceptCyc < j) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDone(input int limit);
    while (!txDone && (cyc - acceptCyc < limit)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runVec(input vecT v, input string tag);
    dataIn       = v.data;
    inverseConv  = v.inv;
    extraGuard   = v.guard;
    clocksPerEtu = 16'(v.cpe);
    check({tag, " readyBefore"}, 32'(txReady), 32'd1);
    accept();
    check({tag, " readyDrop"}, 32'(txReady), 32'd0);
    // Configuration must be latched; disturb the inputs mid-character.
    dataIn       = ~v.data;
    inverseConv  = ~v.inv;
    extraGuard   = 8'd5;
    clocksPerEtu = 16'd9;
    for (int k = 0; k < 10; k++) begin
      waitTo(k * v.cpe + v.cpe / 2);
      check($sformatf("%s bit%0d", tag, k), 32'(serialOut), 32'(v.levels[k]));
    end
    waitDone(v.len + 64);
    check({tag, " doneTime"}, 32'(cyc - acceptCyc), 32'(v.len));
    check({tag, " retry"}, 32'(retryCount), 32'd0);
    check({tag, " noError"}, 32'(txError), 32'd0);
    check({tag, " readyAtDone"}, 32'(txReady), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int e0;
    vecs[0] = '{8'h3B, 1'b0, 8'd0, 16, 10'b1001110110, 192};
    vecs[1] = '{8'h3F, 1'b1, 8'd0, 16, 10'b1000000110, 192};
    vecs[2] = '{8'hA5, 1'b0, 8'd3, 16, 10'b0101001010, 240};
    vecs[3] = '{8'h00, 1'b0, 8'd1, 4,  10'b0000000000, 52};
    vecs[4] = '{8'h80, 1'b1, 8'd2, 5,  10'b0111111100, 70};
    vecs[5] = '{8'hFF, 1'b0, 8'd0, 7,  10'b0111111110, 84};

    nReset = 1'b0;
    startTx = 1'b0;
    errPull = 1'b0;
    clocksPerEtu = 16'd16;
    extraGuard = 8'd0;
    inverseConv = 1'b0;
    dataIn = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst serialOut", 32'(serialOut), 32'd1);
    check("rst txReady", 32'(txReady), 32'd1);
    check("rst txDone", 32'(txDone), 32'd0);
    check("rst txError", 32'(txError), 32'd0);
    check("rst retry", 32'(retryCount), 32'd0);
    nReset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) runVec(vecs[i], $sformatf("vec%0d", i));

    // Start request during guard is ignored; one in the txDone cycle is taken.
    dataIn = 8'h3B; inverseConv = 1'b0; extraGuard = 8'd3; clocksPerEtu = 16'd16;
    accept();
    waitTo(13 * 16);
    startTx = 1'b1;
    @(posedge clk);
    #1;
    startTx = 1'b0;
    check("guard startIgnored ready", 32'(txReady), 32'd0);
    check("guard startIgnored line", 32'(serialOut), 32'd1);
    extraGuard = 8'd0;
    waitDone(300);
    check("guard doneTime", 32'(cyc - acceptCyc), 32'd240);
    startTx = 1'b1;
    @(posedge clk);
    #1;
    acceptCyc = cyc;
    startTx = 1'b0;
    check("b2b startBit", 32'(serialOut), 32'd0);
    check("b2b ready", 32'(txReady), 32'd0);
    waitDone(300);
    check("b2b doneTime", 32'(cyc - acceptCyc), 32'd192);

    // Single error: line pulled low 10.5..11.5 ETU on the first attempt.
    dataIn = 8'h3B; extraGuard = 8'd0; clocksPerEtu = 16'd16;
    accept();
    waitTo(168);
    errPull = 1'b1;
    waitTo(184);
    errPull = 1'b0;
`ifdef ISO7816_TX_ERROR_CHECK_EN
    check("err1 recoverReady", 32'(txReady), 32'd0);
    // Line seen high at cycle 184; resend 2 ETU later.
    waitTo(215);
    check("err1 idleBeforeResend", 32'(serialOut), 32'd1);
    waitTo(216);
    check("err1 resendStart", 32'(serialOut), 32'd0);
    check("err1 retryAtResend", 32'(retryCount), 32'd1);
    waitDone(500);
    check("err1 doneTime", 32'(cyc - acceptCyc), 32'd408);
    check("err1 retryAtDone", 32'(retryCount), 32'd1);
    check("err1 noError", 32'(txError), 32'd0);

    // Error on every attempt: 5 attempts, each 216 cycles apart.
    d0 = doneSeen;
    accept();
    for (int n = 0; n < 5; n++) begin
      waitTo(n * 216 + 168);
      errPull = 1'b1;
      if (n < 4) begin
        waitTo(n * 216 + 184);
        errPull = 1'b0;
      end
    end
    waitTo(1041);
    check("exh txError", 32'(txError), 32'd1);
    check("exh txDone", 32'(txDone), 32'd0);
    check("exh retry", 32'(retryCount), 32'd4);
    check("exh ready", 32'(txReady), 32'd1);
    errPull = 1'b0;
    @(posedge clk);
    #1;
    check("exh pulseLen", 32'(txError), 32'd0);
    check("exh retryHold", 32'(retryCount), 32'd4);
    check("exh noDone", 32'(doneSeen - d0), 32'd0);
`else
    waitDone(300);
    check("noChk doneTime", 32'(cyc - acceptCyc), 32'd192);
    check("noChk retry", 32'(retryCount), 32'd0);
    check("noChk txError", 32'(txError), 32'd0);
`endif

    // Asynchronous reset during bit 4 of an all-zero byte.
    dataIn = 8'h00; extraGuard = 8'd0; clocksPerEtu = 16'd16;
    accept();
    waitTo(72);
    check("rstMid lineLow", 32'(serialOut), 32'd0);
    nReset = 1'b0;
    #2;
    check("rstMid release", 32'(serialOut), 32'd1);
    check("rstMid ready", 32'(txReady), 32'd1);
    check("rstMid retry", 32'(retryCount), 32'd0);
    d0 = doneSeen;
    e0 = errSeen;
    repeat (2) @(posedge clk);
    #1;
    nReset = 1'b1;
    repeat (250) @(posedge clk);
    #1;
    check("rstMid noDone", 32'(doneSeen - d0), 32'd0);
    check("rstMid noError", 32'(errSeen - e0), 32'd0);
    runVec(vecs[0], "afterRst");

    check("neverBoth", 32'(bothSeen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
